integral_buffer_ctrl: RTL and testbench
=======================================

// Module: integral_buffer_ctrl
// PURPOSE
//  Sequencer in front of IntegralBuffer: accepts a raster stream of binary pixels
//  (valid/ready), drives the buffer write port (WriteEnable/Addr/Data), clears it at
//  frame start, and tags which buffer updates hold a complete window. Presents
//  WindowValid/WindowReady to the downstream window classifier and throttles
//  input so an unconsumed window is never shifted out of the buffer.
// PARAMETERS
//  ImageWidth   640  pixels per row
//  ImageHeight  480  rows per frame
//  WindowSize   21   window edge n (same value as the driven IntegralBuffer)
//  PipeLatency  2    cycles from buffer WriteEnable to updated IntegralPacked
// PORTS
//  Clock         in   1                          system clock, rising edge
//  Reset         in   1                          asynchronous, active-low
//  FrameStart    in   1                          1-cycle pulse: new frame follows
//  PixelValid    in   1                          input pixel valid
//  PixelData     in   1                          binary pixel
//  PixelReady    out  1                          pixel accepted when Valid&Ready
//  BufReset      out  1                          sync active-high clear to buffer
//  BufWriteEnable out 1                          buffer WriteEnable
//  BufAddr       out  $clog2(ImageWidth+1)       buffer column address
//  BufData       out  1                          buffer Data
//  BufferReady   in   1                          buffer fill flag
//  WindowValid   out  1                          IntegralPacked holds a complete window
//  WindowReady   in   1                          downstream consumes window
//  WindowRow     out  $clog2(ImageHeight)        row of pixel that completed window
//  WindowCol     out  $clog2(ImageWidth)         column of that pixel
//  FrameDone     out  1                          1-cycle pulse, all windows retired
//  Error         out  1                          sticky: WindowValid w/o BufferReady
// BEHAVIOUR
//  Reset (Reset=0): state IDLE; all outputs 0; row/col counters 0; tag pipe cleared.
//  FSM: IDLE -FrameStart-> CLEAR (1 cycle, BufReset=1) -> STREAM.
//   STREAM -last pixel (row H-1,col W-1) accepted-> DRAIN.
//   DRAIN -tag pipe empty & no WindowValid-> FrameDone=1 for 1 cycle, IDLE.
//   FrameStart in any state other than CLEAR aborts: tag pipe, WindowValid and
//   counters cleared, goto CLEAR. Pixels in IDLE/CLEAR/DRAIN are not accepted.
//  PixelReady = (state==STREAM) & ~WindowValid & (tag pipe empty). Combinational.
//  Accept (PixelValid&PixelReady): next cycle BufWriteEnable=1, BufAddr=col,
//   BufData=PixelData (registered, one cycle wide); col++; at col==W-1 col->0, row++.
//  Window tag = (row>=WindowSize-1) & (col>=2*WindowSize-1) of accepted pixel;
//   tag plus row/col enter a shift pipe of depth 1+PipeLatency.
//  Tag exits pipe -> WindowValid=1, WindowRow/Col latched; held until WindowReady.
//   Accept-to-WindowValid latency = 1+PipeLatency (3 cycles default).
//  WindowValid&WindowReady: WindowValid drops next cycle; pixels resume same cycle
//   as drop. Throughput while windows produced: 1 pixel per (2+PipeLatency) cycles.
//  WindowValid asserting while BufferReady=0 sets Error (cleared only by Reset).
//  Counters sized by $clog2; no wrap beyond frame: DRAIN ignores input.
// STRUCTURE
//  Shared package integral_pkg: FSM state enum (IDLE,CLEAR,STREAM,DRAIN), width
//   localparams/functions for Addr/row/col widths.
//  Sub-module integral_raster_counter: row/col counters with last-pixel flag.
//  Tag pipe and FSM stay in top.
// TESTING (ImageWidth=8, ImageHeight=6, WindowSize=3, PipeLatency=2)
//  Reset low mid-STREAM -> all outputs 0 immediately, state IDLE, PixelReady=0.
//  FrameStart, 48 pixels PixelValid=1, WindowReady=1 -> BufReset one cycle; exactly
//   12 WindowValid pulses; first (Row=2,Col=5) 3 cycles after 22nd accept.
//  Hold WindowReady=0 on first window 10 cycles -> PixelReady=0, no BufWriteEnable,
//   WindowRow/Col stable; release -> stream resumes, totals still 12.
//  PixelValid gaps (random 50%) -> BufAddr sequence 0..7 repeating, 48 writes.
//  FrameStart at pixel 30 -> WindowValid cleared, CLEAR, new frame full 12 windows.
//  Full frame -> FrameDone single pulse after 12th WindowReady; Error stays 0.

Source files
------------

// File: rtl/integral_pkg.sv
// -----------------------------------------------------------------------------
// integral_pkg
// Shared definitions for the IntegralBuffer sequencer:
//   state_t      - sequencer FSM states (IDLE, CLEAR, STREAM, DRAIN)
//   addr_width() - width of the buffer column address, $clog2(ImageWidth+1)
//   col_width()  - width of the column counter, $clog2(ImageWidth)
//   row_width()  - width of the row counter, $clog2(ImageHeight)
// -----------------------------------------------------------------------------
package integral_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // waiting for FrameStart
        CLEAR  = 2'd1,  // one-cycle synchronous clear of the IntegralBuffer
        STREAM = 2'd2,  // accepting raster pixels
        DRAIN  = 2'd3   // last pixel written, retiring the final window
    } state_t;

    // Never returns 0 so degenerate dimensions still give legal vectors.
    function automatic int safe_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    function automatic int addr_width(input int image_width);
        return safe_clog2(image_width + 1);
    endfunction

    function automatic int col_width(input int image_width);
        return safe_clog2(image_width);
    endfunction

    function automatic int row_width(input int image_height);
        return safe_clog2(image_height);
    endfunction

endpackage

// File: rtl/integral_raster_counter.sv
// -----------------------------------------------------------------------------
// integral_raster_counter
// Row/column position of the next pixel in a raster-ordered frame.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : synchronous return to (row 0, col 0)
//   i_advance      : one pixel consumed, step to the next raster position
//   o_row, o_col   : position of the pixel currently offered
//   o_last         : current position is the final pixel of the frame
// The counter wraps to (0,0) after the last pixel, so it never runs past the
// frame even if advanced again.
// -----------------------------------------------------------------------------
module integral_raster_counter
    import integral_pkg::*;
#(
    parameter  int ImageWidth  = 640,
    parameter  int ImageHeight = 480,
    localparam int ColW        = col_width(ImageWidth),
    localparam int RowW        = row_width(ImageHeight)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic            i_advance,
    output logic [RowW-1:0] o_row,
    output logic [ColW-1:0] o_col,
    output logic            o_last
);

    logic [RowW-1:0] r_row;
    logic [ColW-1:0] r_col;
    logic            w_col_end;
    logic            w_row_end;

    assign w_col_end = (r_col == ColW'(ImageWidth - 1));
    assign w_row_end = (r_row == RowW'(ImageHeight - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_col_end & w_row_end;

endmodule

// File: rtl/integral_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// integral_buffer_ctrl
// Sequencer in front of an IntegralBuffer. Accepts a raster stream of binary
// pixels, drives the buffer write port, clears the buffer at frame start and
// flags the buffer updates after which IntegralPacked holds a complete window.
// Input is throttled so a window is never shifted out before it is consumed.
// Ports:
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_frame_start        : 1-cycle pulse, a new frame follows (aborts a running one)
//   i_pixel_valid/_data  : input pixel stream; o_pixel_ready is the handshake
//   o_buf_reset          : synchronous active-high clear to the buffer
//   o_buf_write_enable   : buffer write strobe, with o_buf_addr (column) and o_buf_data
//   i_buffer_ready       : buffer fill flag
//   o_window_valid       : IntegralPacked holds a complete window
//   i_window_ready       : downstream classifier consumes the window
//   o_window_row/_col    : raster position of the pixel that completed the window
//   o_frame_done         : 1-cycle pulse once every window of the frame is retired
//   o_error              : sticky, a window was presented while i_buffer_ready=0
// PipeLatency must be at least 1.
// -----------------------------------------------------------------------------
module integral_buffer_ctrl
    import integral_pkg::*;
#(
    parameter  int ImageWidth  = 640,
    parameter  int ImageHeight = 480,
    parameter  int WindowSize  = 21,
    parameter  int PipeLatency = 2,
    localparam int AddrW       = addr_width(ImageWidth),
    localparam int ColW        = col_width(ImageWidth),
    localparam int RowW        = row_width(ImageHeight)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_frame_start,
    input  logic             i_pixel_valid,
    input  logic             i_pixel_data,
    output logic             o_pixel_ready,
    output logic             o_buf_reset,
    output logic             o_buf_write_enable,
    output logic [AddrW-1:0] o_buf_addr,
    output logic             o_buf_data,
    input  logic             i_buffer_ready,
    output logic             o_window_valid,
    input  logic             i_window_ready,
    output logic [RowW-1:0]  o_window_row,
    output logic [ColW-1:0]  o_window_col,
    output logic             o_frame_done,
    output logic             o_error
);

    state_t r_state;
    state_t w_next_state;

    logic            w_pixel_ready;
    logic            w_accept;
    logic            w_abort;
    logic            w_tag;
    logic            w_pipe_empty;
    logic            w_buf_reset;
    logic            w_frame_done;

    logic [RowW-1:0] w_row;
    logic [ColW-1:0] w_col;
    logic            w_last;

    logic             r_buf_we;
    logic [AddrW-1:0] r_buf_addr;
    logic             r_buf_data;

    // Tag pipe: stage 0 is loaded on accept, the last stage feeds the window
    // register, giving 1+PipeLatency cycles from accept to o_window_valid,
    // i.e. exactly when the buffer has absorbed the write.
    logic [PipeLatency-1:0] r_pipe_valid;
    logic [RowW-1:0]        r_pipe_row [PipeLatency];
    logic [ColW-1:0]        r_pipe_col [PipeLatency];

    logic            r_window_valid;
    logic [RowW-1:0] r_window_row;
    logic [ColW-1:0] r_window_col;
    logic            r_error;

    // FrameStart restarts from any state except CLEAR, which is already a restart.
    assign w_abort = i_frame_start & (r_state != CLEAR);

    // Only one window is ever in flight, so the buffer never shifts past an
    // unconsumed window.
    assign w_pipe_empty  = ~|r_pipe_valid;
    assign w_pixel_ready = (r_state == STREAM) & ~r_window_valid & w_pipe_empty;
    // A pixel coinciding with an abort belongs to the dead frame: dropped.
    assign w_accept      = i_pixel_valid & w_pixel_ready & ~w_abort;

    // The window is complete once its bottom-right pixel is written; the
    // column bound reflects the buffer's packed-window layout.
    assign w_tag = (w_row >= RowW'(WindowSize - 1)) &
                   (w_col >= ColW'(2 * WindowSize - 1));

    integral_raster_counter #(
        .ImageWidth  (ImageWidth),
        .ImageHeight (ImageHeight)
    ) u_raster (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_abort),
        .i_advance (w_accept),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_buf_reset  = 1'b0;
        w_frame_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_frame_start) w_next_state = CLEAR;
            end
            CLEAR: begin
                w_buf_reset  = 1'b1;
                w_next_state = STREAM;
            end
            STREAM: begin
                if (w_abort)                 w_next_state = CLEAR;
                else if (w_accept && w_last) w_next_state = DRAIN;
            end
            DRAIN: begin
                if (w_abort) begin
                    w_next_state = CLEAR;
                end else if (w_pipe_empty && !r_window_valid) begin
                    w_frame_done = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------------------------------------------------- write port
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf_we   <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= 1'b0;
        end else begin
            r_buf_we <= w_accept;
            if (w_accept) begin
                r_buf_addr <= AddrW'(w_col);
                r_buf_data <= i_pixel_data;
            end
        end
    end

    // ------------------------------------------------------------- tag pipe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe_valid <= '0;
        end else if (w_abort) begin
            r_pipe_valid <= '0;
        end else begin
            r_pipe_valid[0] <= w_accept & w_tag;
            for (int i = 1; i < PipeLatency; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
            end
        end
    end

    // NOTE: the row/col payload is only observed when its valid bit is set,
    // so it is deliberately left without reset.
    always_ff @(posedge i_clk) begin
        r_pipe_row[0] <= w_row;
        r_pipe_col[0] <= w_col;
        for (int i = 1; i < PipeLatency; i++) begin
            r_pipe_row[i] <= r_pipe_row[i-1];
            r_pipe_col[i] <= r_pipe_col[i-1];
        end
    end

    // ------------------------------------------------------- window handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_window_valid <= 1'b0;
            r_window_row   <= '0;
            r_window_col   <= '0;
            r_error        <= 1'b0;
        end else begin
            if (w_abort) begin
                r_window_valid <= 1'b0;
            end else if (r_pipe_valid[PipeLatency-1]) begin
                r_window_valid <= 1'b1;
                r_window_row   <= r_pipe_row[PipeLatency-1];
                r_window_col   <= r_pipe_col[PipeLatency-1];
            end else if (r_window_valid && i_window_ready) begin
                r_window_valid <= 1'b0;
            end

            // A window presented from an unfilled buffer is garbage; only
            // reset clears the flag so the event cannot be missed.
            if (r_window_valid && !i_buffer_ready) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_pixel_ready      = w_pixel_ready;
    assign o_buf_reset        = w_buf_reset;
    assign o_buf_write_enable = r_buf_we;
    assign o_buf_addr         = r_buf_addr;
    assign o_buf_data         = r_buf_data;
    assign o_window_valid     = r_window_valid;
    assign o_window_row       = r_window_row;
    assign o_window_col       = r_window_col;
    assign o_frame_done       = w_frame_done;
    assign o_error            = r_error;

endmodule

// File: tb/tb_integral_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_integral_buffer_ctrl
// Self-checking bench for integral_buffer_ctrl on an 8x6 frame, 3x3 window.
// A reference model derives each accepted pixel's raster position from its
// index in the frame, predicts buffer writes and window positions, and a
// monitor compares them with the DUT on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_integral_buffer_ctrl;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int N    = 3;
    localparam int PL   = 2;
    localparam int NWIN = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_frame_start = 1'b0;
    logic       i_pixel_valid = 1'b0;
    logic       i_pixel_data = 1'b0;
    logic       i_buffer_ready = 1'b1;
    logic       i_window_ready = 1'b1;
    logic       o_pixel_ready;
    logic       o_buf_reset;
    logic       o_buf_write_enable;
    logic [3:0] o_buf_addr;
    logic       o_buf_data;
    logic       o_window_valid;
    logic [2:0] o_window_row;
    logic [2:0] o_window_col;
    logic       o_frame_done;
    logic       o_error;

    integral_buffer_ctrl #(
        .ImageWidth  (W),
        .ImageHeight (H),
        .WindowSize  (N),
        .PipeLatency (PL)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_frame_start      (i_frame_start),
        .i_pixel_valid      (i_pixel_valid),
        .i_pixel_data       (i_pixel_data),
        .o_pixel_ready      (o_pixel_ready),
        .o_buf_reset        (o_buf_reset),
        .o_buf_write_enable (o_buf_write_enable),
        .o_buf_addr         (o_buf_addr),
        .o_buf_data         (o_buf_data),
        .i_buffer_ready     (i_buffer_ready),
        .o_window_valid     (o_window_valid),
        .i_window_ready     (i_window_ready),
        .o_window_row       (o_window_row),
        .o_window_col       (o_window_col),
        .o_frame_done       (o_frame_done),
        .o_error            (o_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ----------------------------------------------------- reference model
    typedef struct { int addr; int data; } wr_t;
    typedef struct { int row; int col; int cyc; } win_t;

    wr_t  exp_wr[$];
    win_t exp_win[$];

    int cyc = 0;
    int acc_idx = 0;
    int writes = 0;
    int windows = 0;
    int frame_dones = 0;
    int first_run = -1;
    int first_row = -1;
    int first_col = -1;
    int wv_run = 0;
    int fs_cyc = 0;
    int done_cyc = 0;
    logic       prev_wv = 1'b0;
    logic [2:0] held_row = '0;
    logic [2:0] held_col = '0;

    // Stimulus knobs: pixel valid pattern and first-window backpressure.
    int pix_mode = 0;   // 0 = none, 1 = every cycle, 2 = random 50%
    int hold_left = 0;

    initial forever begin
        @(posedge clk);
        #1;
        case (pix_mode)
            1:       i_pixel_valid = 1'b1;
            2:       i_pixel_valid = 1'($urandom_range(0, 1));
            default: i_pixel_valid = 1'b0;
        endcase
        i_pixel_data = 1'($urandom_range(0, 1));
        if (hold_left > 0 && o_window_valid) begin
            i_window_ready = 1'b0;
            hold_left--;
        end else begin
            i_window_ready = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_wr.delete();
            exp_win.delete();
            acc_idx = 0;
            prev_wv = 1'b0;
            wv_run  = 0;
        end else begin
            if (o_buf_write_enable) begin
                writes++;
                if (exp_wr.size() == 0) begin
                    check("write_unexpected", 1, 0);
                end else begin
                    wr_t wr;
                    wr = exp_wr.pop_front();
                    check("buf_addr", o_buf_addr, wr.addr);
                    check("buf_data", o_buf_data, wr.data);
                end
            end
            if (o_window_valid) begin
                check("ready_while_window", o_pixel_ready, 0);
                check("write_while_window", o_buf_write_enable, 0);
                if (!prev_wv) begin
                    windows++;
                    wv_run   = 1;
                    held_row = o_window_row;
                    held_col = o_window_col;
                    if (first_row < 0) begin
                        first_row = o_window_row;
                        first_col = o_window_col;
                    end
                    if (exp_win.size() == 0) begin
                        check("window_unexpected", 1, 0);
                    end else begin
                        win_t w;
                        w = exp_win.pop_front();
                        check("window_row", o_window_row, w.row);
                        check("window_col", o_window_col, w.col);
                        check("window_latency", cyc - w.cyc, 1 + PL);
                    end
                end else begin
                    wv_run++;
                    check("window_row_stable", o_window_row, held_row);
                    check("window_col_stable", o_window_col, held_col);
                end
            end else if (prev_wv && windows == 1 && first_run < 0) begin
                first_run = wv_run;
            end
            if (o_frame_done) begin
                frame_dones++;
                done_cyc = cyc;
            end
            if (i_frame_start) begin
                exp_win.delete();
                acc_idx     = 0;
                windows     = 0;
                writes      = 0;
                frame_dones = 0;
                first_run   = -1;
                first_row   = -1;
                first_col   = -1;
                fs_cyc      = cyc;
            end else if (i_pixel_valid && o_pixel_ready) begin
                int r;
                int c;
                r = acc_idx / W;
                c = acc_idx % W;
                exp_wr.push_back('{c, int'(i_pixel_data)});
                if (r >= N - 1 && c >= 2 * N - 1) exp_win.push_back('{r, c, cyc});
                acc_idx++;
            end
            prev_wv = o_window_valid;
        end
        cyc++;
    end

    // ---------------------------------------------------------- sequences
    task automatic start_frame();
        @(posedge clk); #1;
        i_frame_start = 1'b1;
        @(posedge clk); #1;
        i_frame_start = 1'b0;
        check("buf_reset_on_start", o_buf_reset, 1);
        check("window_cleared_on_start", o_window_valid, 0);
        @(posedge clk); #1;
        check("buf_reset_single", o_buf_reset, 0);
    endtask

    task automatic wait_frame_done();
        int t;
        t = 0;
        while (frame_dones == 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (10) @(posedge clk);
        #1;
        check("frame_done_pulses", frame_dones, 1);
    endtask

    task automatic check_frame();
        check("window_count", windows, NWIN);
        check("write_count", writes, W * H);
        check("windows_pending", exp_win.size(), 0);
        check("writes_pending", exp_wr.size(), 0);
        check("error_clear", o_error, 0);
    endtask

    task automatic wait_window(input int budget);
        int t;
        t = 0;
        while (!o_window_valid && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check("window_seen", o_window_valid, 1);
    endtask

    initial begin
        #2;
        check("reset_outputs", {o_pixel_ready, o_buf_reset, o_buf_write_enable, o_buf_addr, o_buf_data,
                                o_window_valid, o_window_row, o_window_col, o_frame_done, o_error}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_not_ready", o_pixel_ready, 0);

        // Continuous stream, downstream always ready.
        pix_mode = 1;
        start_frame();
        wait_frame_done();
        check_frame();
        check("first_window_row", first_row, N - 1);
        check("first_window_col", first_col, 2 * N - 1);
        check("frame_done_cycle", done_cyc - fs_cyc, 2 + (W * H - NWIN) + (2 + PL) * NWIN);

        // First window held for 10 cycles.
        hold_left = 10;
        start_frame();
        wait_frame_done();
        check_frame();
        check("held_window_cycles", first_run, 11);

        // Random input gaps.
        pix_mode = 2;
        start_frame();
        wait_frame_done();
        check_frame();

        // Abort at pixel 30 while a window is pending, then a full frame.
        pix_mode = 1;
        start_frame();
        begin
            int t;
            t = 0;
            while (acc_idx < 30 && t < 500) begin
                @(posedge clk); #1;
                t++;
            end
        end
        check("abort_point_reached", acc_idx >= 30, 1);
        hold_left = 1000;
        wait_window(50);
        repeat (2) @(posedge clk);
        start_frame();
        hold_left = 0;
        wait_frame_done();
        check_frame();

        // Window presented from an unfilled buffer, then reset mid-stream.
        i_buffer_ready = 1'b0;
        start_frame();
        wait_window(200);
        repeat (4) @(posedge clk);
        #1;
        check("error_sticky", o_error, 1);
        begin
            int t;
            t = 0;
            while (!o_pixel_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
        end
        check("streaming_before_reset", o_pixel_ready, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("reset_mid_outputs", {o_pixel_ready, o_buf_reset, o_buf_write_enable, o_buf_addr, o_buf_data,
                                    o_window_valid, o_window_row, o_window_col, o_frame_done, o_error}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_buffer_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", o_pixel_ready, 0);
        check("no_write_after_reset", o_buf_write_enable, 0);

        pix_mode = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
